serial_sgt4: RTL and testbench

SERIAL_SGT4 -- requirements
Module: serial_sgt4

---
 rtl/serial_cmp_pkg.sv | 15 +
 rtl/serial_cmp_cell.sv | 28 ++
 rtl/serial_sgt4.sv | 164 ++++++++++++++++
 tb/tb_serial_sgt4.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types and sizing helpers for the bit-serial comparator family.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bits needed to count 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_cmp_cell.sv
// Combinational next-state for the serial signed greater-than (and optional equality).
// Optional equality tracking is enabled by the SERIAL_SGT4_EQ_EN macro.
module serial_cmp_cell (
  input  logic a,
  input  logic b,
  input  logic is_sign,
  input  logic gt_in,
  output logic gt_next
`ifdef SERIAL_SGT4_EQ_EN
  ,
  input  logic eq_in,
  output logic eq_next
`endif
);

  logic same_s;

  assign same_s = ~(a ^ b);

  // On the sign bit a set bit means "more negative", so the win condition flips.
  assign gt_next = is_sign ? ((~a & b) | (same_s & gt_in))
                           : ((a & ~b) | (same_s & gt_in));

`ifdef SERIAL_SGT4_EQ_EN
  assign eq_next = eq_in & same_s;
`endif

endmodule

// File: rtl/serial_sgt4.sv
// Bit-serial signed A > B over WIDTH LSB-first bit pairs with a valid/ready result.
// Define SERIAL_SGT4_EQ_EN to add the EQ output and its tracking register.
module serial_sgt4
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic IVALID,
  output logic IREADY,
  input  logic I0,
  input  logic I1,
  output logic OVALID,
  input  logic OREADY,
  output logic O
`ifdef SERIAL_SGT4_EQ_EN
  ,
  output logic EQ
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

  state_e           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             gt_r, gt_s;
  logic             o_r, o_s;
  logic             ovalid_r, ovalid_s;
  logic             iready_r, iready_s;
  logic             xfer_s;
  logic             is_sign_s;
  logic             gt_in_s;
  logic             cell_gt_s;
`ifdef SERIAL_SGT4_EQ_EN
  logic             eq_r, eq_s;
  logic             eq_out_r, eq_out_s;
  logic             eq_in_s;
  logic             cell_eq_s;
`endif

  assign xfer_s = IVALID & iready_r;

  serial_cmp_cell u_cell (
    .a       (I0),
    .b       (I1),
    .is_sign (is_sign_s),
    .gt_in   (gt_in_s),
    .gt_next (cell_gt_s)
`ifdef SERIAL_SGT4_EQ_EN
    ,
    .eq_in   (eq_in_s),
    .eq_next (cell_eq_s)
`endif
  );

  // Next-state, counter and result capture.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    gt_s      = gt_r;
    o_s       = o_r;
    is_sign_s = 1'b0;
    gt_in_s   = gt_r;
`ifdef SERIAL_SGT4_EQ_EN
    eq_s      = eq_r;
    eq_out_s  = eq_out_r;
    eq_in_s   = eq_r;
`endif
    case (state_r)
      IDLE: begin
        // Bit 0 starts from a clean comparison regardless of leftover state.
        gt_in_s = 1'b0;
`ifdef SERIAL_SGT4_EQ_EN
        eq_in_s = 1'b1;
`endif
        if (xfer_s) begin
          gt_s    = cell_gt_s;
          cnt_s   = {{(CNT_W-1){1'b0}}, 1'b1};
          state_s = SHIFT;
`ifdef SERIAL_SGT4_EQ_EN
          eq_s    = cell_eq_s;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        is_sign_s = (cnt_r == LAST_IDX);
        if (xfer_s) begin
          gt_s = cell_gt_s;
`ifdef SERIAL_SGT4_EQ_EN
          eq_s = cell_eq_s;
`endif
          if (is_sign_s) begin
            o_s     = cell_gt_s;
            cnt_s   = FULL_CNT;
            state_s = DONE;
`ifdef SERIAL_SGT4_EQ_EN
            eq_out_s = cell_eq_s;
`endif
          end else begin
            cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        if (OREADY) begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
          gt_s    = 1'b0;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
        gt_s    = 1'b0;
      end
    endcase
    ovalid_s = (state_s == DONE);
    iready_s = (state_s != DONE);
  end

  // State and output registers; reset discards any partial or pending result.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      gt_r     <= 1'b0;
      o_r      <= 1'b0;
      ovalid_r <= 1'b0;
      iready_r <= 1'b0;
`ifdef SERIAL_SGT4_EQ_EN
      eq_r     <= 1'b0;
      eq_out_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      gt_r     <= gt_s;
      o_r      <= o_s;
      ovalid_r <= ovalid_s;
      iready_r <= iready_s;
`ifdef SERIAL_SGT4_EQ_EN
      eq_r     <= eq_s;
      eq_out_r <= eq_out_s;
`endif
    end
  end

  assign OVALID = ovalid_r;
  assign IREADY = iready_r;
  assign O      = o_r;
`ifdef SERIAL_SGT4_EQ_EN
  assign EQ     = eq_out_r;
`endif

endmodule

// File: tb/tb_serial_sgt4.sv
// Directed bench for serial_sgt4 (WIDTH 4); EQ checks follow SERIAL_SGT4_EQ_EN.
module tb_serial_sgt4;

  logic CLK;
  logic RESETN;
  logic IVALID;
  logic IREADY;
  logic I0;
  logic I1;
  logic OVALID;
  logic OREADY;
  logic O;
`ifdef SERIAL_SGT4_EQ_EN
  logic EQ;
`endif

  int n_checks;
  int n_fail;

  serial_sgt4 #(.WIDTH(4)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .IVALID (IVALID),
    .IREADY (IREADY),
    .I0     (I0),
    .I1     (I1),
    .OVALID (OVALID),
    .OREADY (OREADY),
    .O      (O)
`ifdef SERIAL_SGT4_EQ_EN
    ,
    .EQ     (EQ)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Feed four LSB-first bit pairs, optionally stalling after bit stall_bit, then check the result.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input int stall_bit, input int stall_len,
                        input logic exp_o, input int exp_lat);
    int lat;
    lat = 0;
    for (int k = 0; k < 4; k++) begin
      check({tag, " iready"}, {31'd0, IREADY}, 32'd1);
      IVALID = 1'b1;
      I0 = a[k];
      I1 = b[k];
      tick();
      lat++;
      IVALID = 1'b0;
      if (k == stall_bit) begin
        for (int s = 0; s < stall_len; s++) begin
          tick();
          lat++;
          check({tag, " stall ovalid"}, {31'd0, OVALID}, 32'd0);
        end
      end
      if (k < 3) check({tag, " early ovalid"}, {31'd0, OVALID}, 32'd0);
    end
    check({tag, " ovalid"}, {31'd0, OVALID}, 32'd1);
    check({tag, " o"}, {31'd0, O}, {31'd0, exp_o});
    check({tag, " iready done"}, {31'd0, IREADY}, 32'd0);
    check({tag, " latency"}, lat, exp_lat);
  endtask

  task automatic handshake(input string tag);
    OREADY = 1'b1;
    tick();
    OREADY = 1'b0;
    check({tag, " hs ovalid"}, {31'd0, OVALID}, 32'd0);
    check({tag, " hs iready"}, {31'd0, IREADY}, 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RESETN = 1'b1;
    IVALID = 1'b0;
    OREADY = 1'b0;
    I0 = 1'b0;
    I1 = 1'b0;
    #1;
    RESETN = 1'b0;
    #1;
    check("rst ovalid", {31'd0, OVALID}, 32'd0);
    check("rst o", {31'd0, O}, 32'd0);
    check("rst iready", {31'd0, IREADY}, 32'd0);
`ifdef SERIAL_SGT4_EQ_EN
    check("rst eq", {31'd0, EQ}, 32'd0);
`endif
    tick();
    tick();
    RESETN = 1'b1;
    tick();
    check("post rst iready", {31'd0, IREADY}, 32'd1);
    check("post rst ovalid", {31'd0, OVALID}, 32'd0);

    // 3 > -2
    run_op("3_vs_m2", 4'b0011, 4'b1110, -1, 0, 1'b1, 4);
`ifdef SERIAL_SGT4_EQ_EN
    check("3_vs_m2 eq", {31'd0, EQ}, 32'd0);
`endif
    handshake("3_vs_m2");

    run_op("m8_vs_7", 4'b1000, 4'b0111, -1, 0, 1'b0, 4);
    handshake("m8_vs_7");
    run_op("7_vs_m8", 4'b0111, 4'b1000, -1, 0, 1'b1, 4);
    handshake("7_vs_m8");
    run_op("m1_vs_m2", 4'b1111, 4'b1110, -1, 0, 1'b1, 4);
    handshake("m1_vs_m2");
    run_op("5_vs_5", 4'b0101, 4'b0101, -1, 0, 1'b0, 4);
`ifdef SERIAL_SGT4_EQ_EN
    check("5_vs_5 eq", {31'd0, EQ}, 32'd1);
`endif
    handshake("5_vs_5");

    // Result held in DONE while upstream keeps offering bits.
    run_op("hold", 4'b0111, 4'b1000, -1, 0, 1'b1, 4);
    IVALID = 1'b1;
    I0 = 1'b0;
    I1 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("hold o", {31'd0, O}, 32'd1);
      check("hold ovalid", {31'd0, OVALID}, 32'd1);
      check("hold iready", {31'd0, IREADY}, 32'd0);
    end
    IVALID = 1'b0;
    handshake("hold");
    run_op("after_hold", 4'b0101, 4'b0101, -1, 0, 1'b0, 4);
`ifdef SERIAL_SGT4_EQ_EN
    check("after_hold eq", {31'd0, EQ}, 32'd1);
`endif
    handshake("after_hold");

    // Three idle cycles between bits 1 and 2.
    run_op("stall", 4'b0011, 4'b1110, 1, 3, 1'b1, 7);
    handshake("stall");

    // Reset after bit 2 drops the partial comparison; O still holds 1 from before.
    check("pre rst o", {31'd0, O}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      IVALID = 1'b1;
      I0 = k[0];
      I1 = 1'b0;
      tick();
    end
    IVALID = 1'b0;
    RESETN = 1'b0;
    #1;
    check("mid rst ovalid", {31'd0, OVALID}, 32'd0);
    check("mid rst iready", {31'd0, IREADY}, 32'd0);
    check("mid rst o", {31'd0, O}, 32'd0);
    tick();
    check("mid rst ovalid2", {31'd0, OVALID}, 32'd0);
    RESETN = 1'b1;
    tick();
    check("rel iready", {31'd0, IREADY}, 32'd1);
    check("rel ovalid", {31'd0, OVALID}, 32'd0);
    run_op("1_vs_0", 4'b0001, 4'b0000, -1, 0, 1'b1, 4);
    handshake("1_vs_0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
